waveform_analyzer: RTL and testbench

- Receive-side counterpart to the on-board waveform generators.
- Consumes a 12-bit sample stream (ADC capture or generator loopback) and measures peak maximum, peak minimum and period in samples of a periodic waveform.
- Publishes one measurement set per detected period.
- Feeds the display and self-test logic, which compare measured values against the programmed maximum, minimum and interval.

---
 rtl/waveform_pkg.sv | 30 +++
 rtl/level_crossing_detector.sv | 44 ++++
 rtl/waveform_analyzer.sv | 140 ++++++++++++++
 tb/tb_waveform_analyzer.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/waveform_pkg.sv
`default_nettype none
// ============================================================================
// Module  : waveform_pkg
// Brief   : Shared defaults, FSM encoding and saturating band-limit helpers.
// Rev     : 1.0  initial release
// ============================================================================
package waveform_pkg;

    localparam int unsigned c_sample_w = 12;
    localparam int unsigned c_cnt_w    = 16;
    localparam int unsigned c_hyst     = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_MEASURE = 2'd2
    } state_t;

    function automatic int unsigned sat_sub(input int unsigned a, input int unsigned b);
        return (a > b) ? (a - b) : 32'd0;
    endfunction

    // Operands are sample-sized, so a + b cannot wrap 32 bits.
    function automatic int unsigned sat_add(input int unsigned a, input int unsigned b,
                                            input int unsigned lim);
        return ((a + b) > lim) ? lim : (a + b);
    endfunction

endpackage
`default_nettype wire

// File: rtl/level_crossing_detector.sv
`default_nettype none
// ============================================================================
// Module  : level_crossing_detector
// Brief   : Hysteretic rising-crossing strobe around a supplied threshold.
// Rev     : 1.0  initial release
// ============================================================================
module level_crossing_detector
    import waveform_pkg::*;
#(
    parameter int unsigned SAMPLE_W = c_sample_w,
    parameter int unsigned HYST     = c_hyst
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                i_sample_valid,
    input  logic [SAMPLE_W-1:0] i_sample,
    input  logic [SAMPLE_W-1:0] i_thr,
    output logic                o_rise
);

    localparam int unsigned c_full = (32'd1 << SAMPLE_W) - 32'd1;

    logic                r_arm;
    logic [SAMPLE_W-1:0] w_band_lo;
    logic [SAMPLE_W-1:0] w_band_hi;

    assign w_band_lo = SAMPLE_W'(sat_sub(32'(i_thr), HYST));
    assign w_band_hi = SAMPLE_W'(sat_add(32'(i_thr), HYST, c_full));
    assign o_rise    = i_sample_valid & r_arm & (i_sample >= w_band_hi);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_arm <= 1'b0;
        end else if (i_sample_valid) begin
            if (o_rise) begin
                r_arm <= 1'b0;
            end else if (i_sample < w_band_lo) begin
                r_arm <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/waveform_analyzer.sv
`default_nettype none
// ============================================================================
// Module  : waveform_analyzer
// Brief   : Measures max, min and period of a periodic sample stream.
// Rev     : 1.0  initial release
// ============================================================================
module waveform_analyzer
    import waveform_pkg::*;
#(
    parameter int unsigned SAMPLE_W = c_sample_w,
    parameter int unsigned CNT_W    = c_cnt_w,
    parameter int unsigned HYST     = c_hyst
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample,
    output logic [SAMPLE_W-1:0] meas_max,
    output logic [SAMPLE_W-1:0] meas_min,
    output logic [CNT_W-1:0]    meas_period,
    output logic                meas_valid,
    output logic                locked,
    output logic                timeout
);

    // One below saturation: the increment that would reach all-ones times out instead.
    localparam logic [CNT_W-1:0] c_cnt_last = {{(CNT_W-1){1'b1}}, 1'b0};

    state_t              r_state,  w_state_nxt;
    logic [SAMPLE_W-1:0] r_max,    w_max_nxt;
    logic [SAMPLE_W-1:0] r_min,    w_min_nxt;
    logic [SAMPLE_W-1:0] r_thr,    w_thr_nxt;
    logic [CNT_W-1:0]    r_cnt,    w_cnt_nxt;
    logic [SAMPLE_W-1:0] w_mmax_nxt, w_mmin_nxt;
    logic [CNT_W-1:0]    w_mper_nxt;
    logic                w_valid_nxt, w_locked_nxt, w_timeout_nxt;

    logic [SAMPLE_W:0]   w_sum;
    logic [SAMPLE_W-1:0] w_mid;
    logic [SAMPLE_W-1:0] w_det_thr;
    logic                w_rise;

    assign w_sum     = {1'b0, r_max} + {1'b0, r_min};
    assign w_mid     = w_sum[SAMPLE_W:1];
    assign w_det_thr = (r_state == ST_MEASURE) ? r_thr : w_mid;

    level_crossing_detector #(
        .SAMPLE_W (SAMPLE_W),
        .HYST     (HYST)
    ) u_detector (
        .clock          (clock),
        .resetn         (resetn),
        .i_sample_valid (sample_valid),
        .i_sample       (sample),
        .i_thr          (w_det_thr),
        .o_rise         (w_rise)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_max_nxt     = r_max;
        w_min_nxt     = r_min;
        w_thr_nxt     = r_thr;
        w_cnt_nxt     = r_cnt;
        w_mmax_nxt    = meas_max;
        w_mmin_nxt    = meas_min;
        w_mper_nxt    = meas_period;
        w_valid_nxt   = 1'b0;
        w_locked_nxt  = locked;
        w_timeout_nxt = 1'b0;
        if (sample_valid) begin
            case (r_state)
                ST_IDLE: begin
                    w_max_nxt   = sample;
                    w_min_nxt   = sample;
                    w_cnt_nxt   = {{(CNT_W-1){1'b0}}, 1'b1};
                    w_state_nxt = ST_ACQUIRE;
                end
                ST_ACQUIRE, ST_MEASURE: begin
                    if (w_rise) begin
                        if (r_state == ST_MEASURE) begin
                            w_mmax_nxt   = r_max;
                            w_mmin_nxt   = r_min;
                            w_mper_nxt   = r_cnt;
                            w_valid_nxt  = 1'b1;
                            w_locked_nxt = 1'b1;
                        end
                        w_thr_nxt   = w_mid;
                        w_max_nxt   = sample;
                        w_min_nxt   = sample;
                        w_cnt_nxt   = {{(CNT_W-1){1'b0}}, 1'b1};
                        w_state_nxt = ST_MEASURE;
                    end else if (r_cnt == c_cnt_last) begin
                        w_timeout_nxt = 1'b1;
                        w_locked_nxt  = 1'b0;
                        w_max_nxt     = sample;
                        w_min_nxt     = sample;
                        w_cnt_nxt     = {{(CNT_W-1){1'b0}}, 1'b1};
                        w_state_nxt   = ST_ACQUIRE;
                    end else begin
                        w_max_nxt = (sample > r_max) ? sample : r_max;
                        w_min_nxt = (sample < r_min) ? sample : r_min;
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_max       <= '0;
            r_min       <= '0;
            r_thr       <= '0;
            r_cnt       <= '0;
            meas_max    <= '0;
            meas_min    <= '0;
            meas_period <= '0;
            meas_valid  <= 1'b0;
            locked      <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_max       <= w_max_nxt;
            r_min       <= w_min_nxt;
            r_thr       <= w_thr_nxt;
            r_cnt       <= w_cnt_nxt;
            meas_max    <= w_mmax_nxt;
            meas_min    <= w_mmin_nxt;
            meas_period <= w_mper_nxt;
            meas_valid  <= w_valid_nxt;
            locked      <= w_locked_nxt;
            timeout     <= w_timeout_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_waveform_analyzer.sv
`default_nettype none
// ============================================================================
// Module  : tb_waveform_analyzer
// Brief   : Self-checking bench for waveform_analyzer against a sample-level model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_waveform_analyzer;

    localparam int SW    = 12;
    localparam int CW    = 10;   // narrower counter keeps saturation scenarios short
    localparam int HY    = 16;
    localparam int LIMIT = (1 << CW) - 1;

    logic          clock        = 1'b0;
    logic          resetn       = 1'b1;
    logic          sample_valid = 1'b0;
    logic [SW-1:0] sample       = '0;
    logic [SW-1:0] meas_max, meas_min;
    logic [CW-1:0] meas_period;
    logic          meas_valid, locked, timeout;

    always #5 clock = ~clock;

    waveform_analyzer #(.SAMPLE_W(SW), .CNT_W(CW), .HYST(HY)) dut (
        .clock        (clock),
        .resetn       (resetn),
        .sample_valid (sample_valid),
        .sample       (sample),
        .meas_max     (meas_max),
        .meas_min     (meas_min),
        .meas_period  (meas_period),
        .meas_valid   (meas_valid),
        .locked       (locked),
        .timeout      (timeout)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state: trackers, counter, latched threshold, arm flag.
    int m_max, m_min, m_cnt, m_thr;
    bit m_started, m_measuring, m_arm;
    logic [SW-1:0] e_max, e_min;
    logic [CW-1:0] e_period;
    logic          e_valid, e_locked, e_timeout;

    function automatic logic [3*1+2*SW+CW-1:0] obs();
        return {meas_valid, timeout, locked, meas_max, meas_min, meas_period};
    endfunction

    function automatic logic [3*1+2*SW+CW-1:0] expv();
        return {e_valid, e_timeout, e_locked, e_max, e_min, e_period};
    endfunction

    function automatic int tri_wave(input int i);
        int p;
        p = i % 100;
        return (p < 50) ? p * 81 : 4000 - (p - 50) * 81;
    endfunction

    task automatic model_reset();
        m_max = 0; m_min = 0; m_cnt = 0; m_thr = 0;
        m_started = 0; m_measuring = 0; m_arm = 0;
        e_max = '0; e_min = '0; e_period = '0;
        e_valid = 0; e_locked = 0; e_timeout = 0;
    endtask

    task automatic model_step(input bit v, input int s);
        int thr, lo, hi;
        bit rise;
        e_valid   = 0;
        e_timeout = 0;
        if (!v) return;
        thr  = m_measuring ? m_thr : (m_max + m_min) / 2;
        lo   = (thr > HY) ? thr - HY : 0;
        hi   = (thr + HY > 4095) ? 4095 : thr + HY;
        rise = m_arm && (s >= hi);
        if (rise) m_arm = 0;
        else if (s < lo) m_arm = 1;
        if (!m_started) begin
            m_started = 1; m_max = s; m_min = s; m_cnt = 1;
        end else if (rise) begin
            if (m_measuring) begin
                e_max = 12'(m_max); e_min = 12'(m_min); e_period = CW'(m_cnt);
                e_valid = 1; e_locked = 1;
            end
            m_thr = (m_max + m_min) / 2;
            m_measuring = 1; m_max = s; m_min = s; m_cnt = 1;
        end else if (m_cnt + 1 == LIMIT) begin
            e_timeout = 1; e_locked = 0;
            m_measuring = 0; m_max = s; m_min = s; m_cnt = 1;
        end else begin
            if (s > m_max) m_max = s;
            if (s < m_min) m_min = s;
            m_cnt++;
        end
    endtask

    task automatic step(input bit v, input int s);
        sample_valid = v;
        sample       = 12'(s);
        @(posedge clock);
        model_step(v, s);
        #1;
    endtask

    task automatic apply_reset();
        resetn = 1'b0;
        sample_valid = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        @(negedge clock);
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        resetn = 1'b0;
        sample_valid = 1'b1;
        sample = 12'd123;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        n_vec++;
        if (obs() !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs got %h want 0", obs());
        end
        @(negedge clock);
        resetn = 1'b1;
        sample_valid = 1'b0;
    endtask

    task automatic test_triangle();
        int pulses = 0, last = -1;
        apply_reset();
        for (int i = 0; i < 600; i++) begin
            step(1'b1, tri_wave(i));
            n_vec++;
            if (obs() !== expv()) begin
                n_bad++;
                $display("FAIL triangle i=%0d got %h want %h", i, obs(), expv());
            end
            if (meas_valid) begin
                if (pulses >= 1) begin
                    n_vec++;
                    if (meas_period !== 10'd100 || meas_max !== 12'd4000 || meas_min !== 12'd0 || i - last != 100) begin
                        n_bad++;
                        $display("FAIL triangle_meas i=%0d got per=%0d max=%0d min=%0d gap=%0d want 100/4000/0/100",
                                 i, meas_period, meas_max, meas_min, i - last);
                    end
                end
                pulses++;
                last = i;
            end
        end
        n_vec++;
        if (pulses != 4 || locked !== 1'b1) begin
            n_bad++;
            $display("FAIL triangle_count got pulses=%0d locked=%b want 4/1", pulses, locked);
        end
    endtask

    task automatic test_half_rate();
        int pulses = 0, last = -1, k = 0;
        apply_reset();
        for (int c = 0; c < 1200; c++) begin
            bit v;
            v = (c % 2 == 0);
            step(v, tri_wave(k));
            if (v) k++;
            n_vec++;
            if (obs() !== expv()) begin
                n_bad++;
                $display("FAIL half_rate c=%0d got %h want %h", c, obs(), expv());
            end
            if (meas_valid) begin
                if (pulses >= 1) begin
                    n_vec++;
                    if (meas_period !== 10'd100 || meas_max !== 12'd4000 || meas_min !== 12'd0 || c - last != 200) begin
                        n_bad++;
                        $display("FAIL half_rate_meas c=%0d got per=%0d max=%0d min=%0d gap=%0d want 100/4000/0/200",
                                 c, meas_period, meas_max, meas_min, c - last);
                    end
                end
                pulses++;
                last = c;
            end
        end
    endtask

    task automatic test_flat();
        int tos = 0, first = -1, valids = 0;
        apply_reset();
        for (int i = 0; i < 2 * LIMIT + 20; i++) begin
            step(1'b1, 2048);
            n_vec++;
            if (obs() !== expv()) begin
                n_bad++;
                $display("FAIL flat i=%0d got %h want %h", i, obs(), expv());
            end
            if (timeout) begin
                if (first < 0) first = i;
                tos++;
            end
            if (meas_valid || locked) valids++;
        end
        n_vec++;
        if (tos != 2 || first != LIMIT - 1 || valids != 0) begin
            n_bad++;
            $display("FAIL flat_timeouts got count=%0d first=%0d valid/locked=%0d want 2/%0d/0",
                     tos, first, valids, LIMIT - 1);
        end
    endtask

    task automatic test_square();
        int tos = 0, pulses = 0;
        apply_reset();
        for (int i = 0; i < LIMIT + 50; i++) begin
            step(1'b1, (i % 2 == 0) ? 1000 : 1010);
            n_vec++;
            if (obs() !== expv()) begin
                n_bad++;
                $display("FAIL square_low i=%0d got %h want %h", i, obs(), expv());
            end
            if (timeout) tos++;
            if (meas_valid) pulses++;
        end
        n_vec++;
        if (tos != 1 || pulses != 0) begin
            n_bad++;
            $display("FAIL square_low_count got timeouts=%0d valids=%0d want 1/0", tos, pulses);
        end
        apply_reset();
        pulses = 0;
        for (int i = 0; i < 200; i++) begin
            step(1'b1, ((i % 20) < 10) ? 3000 : 100);
            n_vec++;
            if (obs() !== expv()) begin
                n_bad++;
                $display("FAIL square i=%0d got %h want %h", i, obs(), expv());
            end
            if (meas_valid) begin
                pulses++;
                n_vec++;
                if (meas_period !== 10'd20 || meas_max !== 12'd3000 || meas_min !== 12'd100) begin
                    n_bad++;
                    $display("FAIL square_meas i=%0d got %0d/%0d/%0d want 20/3000/100",
                             i, meas_period, meas_max, meas_min);
                end
            end
        end
    endtask

    task automatic test_random_square();
        for (int r = 0; r < 4; r++) begin
            int lo, hi, half, pulses;
            lo = $urandom_range(0, 1500);
            hi = $urandom_range(2500, 4095);
            half = $urandom_range(3, 30);
            pulses = 0;
            apply_reset();
            for (int i = 0; i < 20 * half; i++) begin
                bit v;
                v = ($urandom_range(0, 3) != 0) || (i < 4 * half);
                step(1'b1, ((i % (2 * half)) < half) ? hi : lo);
                n_vec++;
                if (obs() !== expv()) begin
                    n_bad++;
                    $display("FAIL rand_square r=%0d i=%0d got %h want %h", r, i, obs(), expv());
                end
                if (meas_valid) begin
                    n_vec++;
                    if (meas_period !== CW'(2 * half) || meas_max !== 12'(hi) || meas_min !== 12'(lo)) begin
                        n_bad++;
                        $display("FAIL rand_square_meas got %0d/%0d/%0d want %0d/%0d/%0d",
                                 meas_period, meas_max, meas_min, 2 * half, hi, lo);
                    end
                    pulses++;
                end
                if (!v) step(1'b0, $urandom_range(0, 4095));
            end
        end
    endtask

    task automatic test_reset_mid();
        int first = -1;
        apply_reset();
        for (int i = 0; i < 260; i++) step(1'b1, tri_wave(i));
        #2;
        resetn = 1'b0;
        model_reset();
        #1;
        n_vec++;
        if (obs() !== '0) begin
            n_bad++;
            $display("FAIL reset_mid_outputs got %h want 0", obs());
        end
        @(negedge clock);
        resetn = 1'b1;
        for (int j = 0; j < 400; j++) begin
            step(1'b1, tri_wave(260 + j));
            n_vec++;
            if (obs() !== expv()) begin
                n_bad++;
                $display("FAIL reset_mid j=%0d got %h want %h", j, obs(), expv());
            end
            if (meas_valid && first < 0) first = j;
        end
        n_vec++;
        if (first < 100) begin
            n_bad++;
            $display("FAIL reset_mid_first got %0d want >=100", first);
        end
    endtask

    task automatic test_hold();
        int tos = 0;
        apply_reset();
        for (int i = 0; i < 350; i++) step(1'b1, tri_wave(i));
        for (int i = 0; i < LIMIT + 20; i++) begin
            step(1'b1, 4000);
            n_vec++;
            if (obs() !== expv()) begin
                n_bad++;
                $display("FAIL hold i=%0d got %h want %h", i, obs(), expv());
            end
            if (timeout) begin
                tos++;
                n_vec++;
                if (locked !== 1'b0 || meas_max !== 12'd4000 || meas_min !== 12'd0 || meas_period !== 10'd100) begin
                    n_bad++;
                    $display("FAIL hold_timeout got l=%b %0d/%0d/%0d want 0 4000/0/100",
                             locked, meas_max, meas_min, meas_period);
                end
            end
        end
        for (int i = 350; i < 750; i++) begin
            step(1'b1, tri_wave(i));
            n_vec++;
            if (obs() !== expv()) begin
                n_bad++;
                $display("FAIL relock i=%0d got %h want %h", i, obs(), expv());
            end
        end
        n_vec++;
        if (tos != 1 || locked !== 1'b1) begin
            n_bad++;
            $display("FAIL hold_relock got timeouts=%0d locked=%b want 1/1", tos, locked);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_triangle();
        test_half_rate();
        test_flat();
        test_square();
        test_random_square();
        test_reset_mid();
        test_hold();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
